// File: rtl/dsp48a1_mac_seq.sv
// dsp48a1_mac_seq: steers one DSP48A1 slice (A1/B1/M/P/OPMODE registered) as a streaming MAC.
// Optional per-pair subtraction (P = Z - M) when DSP48A1_MAC_SEQ_SUB_EN is defined.
module dsp48a1_mac_seq #(
  parameter int LEN_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             ABORT,
  output logic             BUSY,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [17:0]      IN_A,
  input  logic [17:0]      IN_B,
`ifdef DSP48A1_MAC_SEQ_SUB_EN
  input  logic             IN_SUB,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [47:0]      OUT_P,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic             DSP_CEA,
  output logic             DSP_CEB,
  output logic             DSP_CEM,
  output logic             DSP_CEP,
  output logic             DSP_CEOPMODE,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_RST,
  input  logic [47:0]      DSP_P
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q;
  logic [LEN_W-1:0] rem_q;
  logic             first_q;
  logic             t1_valid_q, t1_first_q, t1_last_q;
  logic             t1_valid_d, t1_first_d, t1_last_d;
  logic             t2_valid_q, t2_last_q;
  logic             cap_q;
  logic [47:0]      out_p_q;
  logic             dsp_rst_q;
  logic             accept;
  logic             sub_bit;

`ifdef DSP48A1_MAC_SEQ_SUB_EN
  logic t1_sub_q, t1_sub_d;
`endif

  assign accept = IN_VALID && (state_q == RUN);

  always_comb begin
    t1_valid_d = accept;
    t1_first_d = accept && first_q;
    t1_last_d  = accept && (rem_q == LEN_W'(1));
  end

`ifdef DSP48A1_MAC_SEQ_SUB_EN
  assign t1_sub_d = accept && IN_SUB;
  assign sub_bit  = t1_valid_q && t1_sub_q;
`else
  assign sub_bit  = 1'b0;
`endif

  // Tags follow the pair through A1/B1 (t1), M (t2); cap_q marks that P now holds the last sum.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      first_q    <= 1'b0;
      t1_valid_q <= 1'b0;
      t1_first_q <= 1'b0;
      t1_last_q  <= 1'b0;
      t2_valid_q <= 1'b0;
      t2_last_q  <= 1'b0;
      cap_q      <= 1'b0;
      out_p_q    <= '0;
      dsp_rst_q  <= 1'b1;
`ifdef DSP48A1_MAC_SEQ_SUB_EN
      t1_sub_q   <= 1'b0;
`endif
    end else begin
      dsp_rst_q  <= 1'b0;
      t1_valid_q <= t1_valid_d;
      t1_first_q <= t1_first_d;
      t1_last_q  <= t1_last_d;
      t2_valid_q <= t1_valid_q;
      t2_last_q  <= t1_valid_q && t1_last_q;
      cap_q      <= t2_valid_q && t2_last_q;
`ifdef DSP48A1_MAC_SEQ_SUB_EN
      t1_sub_q   <= t1_sub_d;
`endif
      case (state_q)
        IDLE: begin
          if (START) begin
            if (LEN == '0) begin
              out_p_q <= '0;
              state_q <= DONE;
            end else begin
              rem_q   <= LEN;
              first_q <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN, DRAIN: begin
          if (ABORT) begin
            t1_valid_q <= 1'b0;
            t1_first_q <= 1'b0;
            t1_last_q  <= 1'b0;
            t2_valid_q <= 1'b0;
            t2_last_q  <= 1'b0;
            cap_q      <= 1'b0;
            first_q    <= 1'b0;
`ifdef DSP48A1_MAC_SEQ_SUB_EN
            t1_sub_q   <= 1'b0;
`endif
            state_q    <= IDLE;
          end else if (state_q == RUN) begin
            if (accept) begin
              rem_q   <= rem_q - LEN_W'(1);
              first_q <= 1'b0;
              if (rem_q == LEN_W'(1)) state_q <= DRAIN;
            end
          end else if (cap_q) begin
            out_p_q <= DSP_P;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign BUSY         = (state_q != IDLE);
  assign IN_READY     = (state_q == RUN);
  assign OUT_VALID    = (state_q == DONE);
  assign OUT_P        = out_p_q;
  assign DSP_A        = accept ? IN_A : '0;
  assign DSP_B        = accept ? IN_B : '0;
  assign DSP_CEA      = accept;
  assign DSP_CEB      = accept;
  assign DSP_CEM      = t1_valid_q;
  assign DSP_CEP      = t2_valid_q;
  assign DSP_CEOPMODE = 1'b1;
  assign DSP_RST      = dsp_rst_q;

  // First pair loads Z=0 so no residue from earlier jobs survives in P.
  assign DSP_OPMODE = {sub_bit, 3'b000,
                       t1_valid_q ? (t1_first_q ? 4'b0001 : 4'b1001) : 4'b0000};

endmodule
